// File: rtl/board_level_data_block_transmitter_if.sv
// Handshake bundle between a block source, the block transmitter and the byte-level tx stream.
interface board_level_data_block_transmitter_if #(
    parameter int BYTE_N = 8
);
    logic [BYTE_N*8-1:0] in_data;
    logic                in_valid;
    logic                in_ready;
    logic                busy;
    logic                done;
    logic                tx_frame_start;
    logic                tx_frame_end;
    logic [7:0]          tx_data;
    logic                tx_valid;
    logic                tx_ready;

    modport master (
        output in_data, in_valid, tx_ready,
        input  in_ready, busy, done, tx_frame_start, tx_frame_end, tx_data, tx_valid
    );

    modport slave (
        input  in_data, in_valid, tx_ready,
        output in_ready, busy, done, tx_frame_start, tx_frame_end, tx_data, tx_valid
    );
endinterface

// File: rtl/board_level_data_block_transmitter.sv
// Frames one BYTE_N-byte block as start marker, payload bytes (byte 0 first), end marker,
// with optional idle gap before the next block is accepted.
module board_level_data_block_transmitter #(
    parameter int BYTE_N     = 8,
    parameter int GAP_CYCLES = 0
) (
    input  logic                                 clk,
    input  logic                                 rst,
    board_level_data_block_transmitter_if.slave  bus
);
    localparam int CNT_W = $clog2(BYTE_N + 1);
    localparam int GAP_W = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BYTE_N - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    typedef enum logic [2:0] {S_IDLE, S_START, S_PAYLOAD, S_END, S_GAP} state_t;

    state_t              state_q, state_d;
    logic [BYTE_N*8-1:0] shreg_q, shreg_d, shreg_shift;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [GAP_W-1:0]    gap_q, gap_d;
    logic                tx_valid_q, tx_valid_d;
    logic                sof_q, sof_d;
    logic                eof_q, eof_d;
    logic [7:0]          tx_data_q, tx_data_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                tx_fire;

    assign shreg_shift = shreg_q >> 8;
    assign tx_fire     = tx_valid_q && bus.tx_ready;

    // Outputs are computed for the next state so every tx_* signal leaves a flop;
    // without a transfer all of them keep their current value.
    always_comb begin
        state_d    = state_q;
        shreg_d    = shreg_q;
        cnt_d      = cnt_q;
        gap_d      = gap_q;
        tx_valid_d = tx_valid_q;
        sof_d      = sof_q;
        eof_d      = eof_q;
        tx_data_d  = tx_data_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.in_valid) begin
                    shreg_d    = bus.in_data;
                    cnt_d      = '0;
                    state_d    = S_START;
                    tx_valid_d = 1'b1;
                    sof_d      = 1'b1;
                    eof_d      = 1'b0;
                    tx_data_d  = 8'h00;
                    busy_d     = 1'b1;
                end
            end
            S_START: begin
                if (tx_fire) begin
                    state_d   = S_PAYLOAD;
                    sof_d     = 1'b0;
                    tx_data_d = shreg_q[7:0];
                end
            end
            S_PAYLOAD: begin
                if (tx_fire) begin
                    shreg_d = shreg_shift;
                    cnt_d   = cnt_q + 1'b1;
                    if (cnt_q == CNT_LAST) begin
                        state_d   = S_END;
                        eof_d     = 1'b1;
                        tx_data_d = 8'h00;
                    end else begin
                        tx_data_d = shreg_shift[7:0];
                    end
                end
            end
            S_END: begin
                if (tx_fire) begin
                    done_d     = 1'b1;
                    tx_valid_d = 1'b0;
                    eof_d      = 1'b0;
                    if (GAP_CYCLES > 0) begin
                        state_d = S_GAP;
                        gap_d   = '0;
                    end else begin
                        state_d = S_IDLE;
                        busy_d  = 1'b0;
                    end
                end
            end
            S_GAP: begin
                if (gap_q == GAP_LAST) begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            default: begin
                state_d    = S_IDLE;
                tx_valid_d = 1'b0;
                busy_d     = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            shreg_q    <= '0;
            cnt_q      <= '0;
            gap_q      <= '0;
            tx_valid_q <= 1'b0;
            sof_q      <= 1'b0;
            eof_q      <= 1'b0;
            tx_data_q  <= 8'h00;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            shreg_q    <= shreg_d;
            cnt_q      <= cnt_d;
            gap_q      <= gap_d;
            tx_valid_q <= tx_valid_d;
            sof_q      <= sof_d;
            eof_q      <= eof_d;
            tx_data_q  <= tx_data_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign bus.in_ready       = (state_q == S_IDLE) && !rst;
    assign bus.busy           = busy_q;
    assign bus.done           = done_q;
    assign bus.tx_frame_start = sof_q;
    assign bus.tx_frame_end   = eof_q;
    assign bus.tx_data        = tx_data_q;
    assign bus.tx_valid       = tx_valid_q;
endmodule

// File: tb/tb_board_level_data_block_transmitter.sv
// Bench for the block transmitter: an 8-byte no-gap instance and a 1-byte instance with a 2-cycle gap.
module tb_board_level_data_block_transmitter;
    localparam int N8 = 8;
    localparam int N1 = 1;
    localparam int G1 = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    board_level_data_block_transmitter_if #(.BYTE_N(N8)) b8 ();
    board_level_data_block_transmitter_if #(.BYTE_N(N1)) b1 ();

    board_level_data_block_transmitter #(.BYTE_N(N8), .GAP_CYCLES(0)) dut8 (
        .clk(clk), .rst(rst), .bus(b8)
    );
    board_level_data_block_transmitter #(.BYTE_N(N1), .GAP_CYCLES(G1)) dut1 (
        .clk(clk), .rst(rst), .bus(b1)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Sends one block on the 8-byte instance and walks it cycle by cycle against the
    // expected beat list. mode: 0 ready always, 1 ready toggles 1,0,..., 2 random ready.
    task automatic frame8(input logic [63:0] data, input int mode, input bit disturb);
        logic [9:0] exp_q[$];
        bit         done_exp;
        bit         fin;
        bit         rdy;
        int         stalls;
        @(negedge clk);
        chk("in_ready_before", 64'(b8.in_ready), 64'(1));
        b8.in_valid = 1'b1;
        b8.in_data  = data;
        @(posedge clk);
        #1;
        b8.in_valid = 1'b0;
        b8.in_data  = {$urandom(), $urandom()};
        exp_q = {};
        exp_q.push_back(10'h200);
        for (int k = 0; k < N8; k++) exp_q.push_back({2'b00, data[8*k +: 8]});
        exp_q.push_back(10'h100);
        done_exp = 1'b0;
        fin      = 1'b0;
        stalls   = 0;
        for (int cyc = 1; cyc <= 300 && !fin; cyc++) begin
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = (cyc % 2) == 1;
                default: rdy = ($urandom_range(0, 3) != 0);
            endcase
            b8.tx_ready = rdy;
            if (disturb && cyc == 4) begin
                b8.in_valid = 1'b1;
                b8.in_data  = ~data;
            end else begin
                b8.in_valid = 1'b0;
            end
            @(negedge clk);
            chk("tx_valid", 64'(b8.tx_valid), 64'(exp_q.size() != 0));
            if (exp_q.size() != 0)
                chk("beat", 64'({b8.tx_frame_start, b8.tx_frame_end, b8.tx_data}), 64'(exp_q[0]));
            chk("busy", 64'(b8.busy), 64'(exp_q.size() != 0));
            chk("done", 64'(b8.done), 64'(done_exp));
            chk("in_ready", 64'(b8.in_ready), 64'(exp_q.size() == 0));
            if (done_exp) begin
                chk("done_cycle", 64'(cyc), 64'(N8 + 3 + stalls));
                fin = 1'b1;
            end else if (rdy) begin
                void'(exp_q.pop_front());
                if (exp_q.size() == 0) done_exp = 1'b1;
            end else begin
                stalls++;
            end
            @(posedge clk);
            #1;
        end
        if (!fin) chk("frame_timeout", 64'(0), 64'(1));
        b8.in_valid = 1'b0;
        b8.tx_ready = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("idle_tx_valid", 64'(b8.tx_valid), 64'(0));
            chk("idle_done", 64'(b8.done), 64'(0));
        end
    endtask

    initial begin
        logic [63:0] d;
        logic [9:0]  e1;
        int          ph;
        rst         = 1'b1;
        b8.in_valid = 1'b0;
        b8.in_data  = '0;
        b8.tx_ready = 1'b1;
        b1.in_valid = 1'b0;
        b1.in_data  = '0;
        b1.tx_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst_tx_valid", 64'(b8.tx_valid), 64'(0));
        chk("rst_busy", 64'(b8.busy), 64'(0));
        chk("rst_done", 64'(b8.done), 64'(0));
        chk("rst_in_ready", 64'(b8.in_ready), 64'(0));
        chk("rst_tx_data", 64'(b8.tx_data), 64'(0));
        chk("rst1_tx_valid", 64'(b1.tx_valid), 64'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_in_ready", 64'(b8.in_ready), 64'(1));
        chk("post_rst_in_ready1", 64'(b1.in_ready), 64'(1));

        frame8(64'h0807060504030201, 0, 1'b0);
        frame8(64'h0807060504030201, 1, 1'b0);
        frame8({$urandom(), $urandom()}, 0, 1'b1);

        // Reset while payload byte 3 is on the stream.
        d = {$urandom(), $urandom()};
        @(negedge clk);
        b8.in_valid = 1'b1;
        b8.in_data  = d;
        @(posedge clk);
        #1;
        b8.in_valid = 1'b0;
        b8.tx_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        chk("mid_byte3", 64'(b8.tx_data), 64'(d[31:24]));
        chk("mid_valid", 64'(b8.tx_valid), 64'(1));
        @(negedge clk);
        chk("mid_rst_tx_valid", 64'(b8.tx_valid), 64'(0));
        chk("mid_rst_busy", 64'(b8.busy), 64'(0));
        chk("mid_rst_done", 64'(b8.done), 64'(0));
        chk("mid_rst_eof", 64'(b8.tx_frame_end), 64'(0));
        chk("mid_rst_in_ready", 64'(b8.in_ready), 64'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("mid_rel_in_ready", 64'(b8.in_ready), 64'(1));
        chk("mid_rel_tx_valid", 64'(b8.tx_valid), 64'(0));
        frame8({$urandom(), $urandom()}, 0, 1'b0);

        for (int f = 0; f < 4; f++) frame8({$urandom(), $urandom()}, 2, 1'b0);

        // One-byte block, 2-cycle gap, in_valid held: the frame repeats every N1+3+G1 cycles.
        @(negedge clk);
        b1.in_data  = 8'hA5;
        b1.in_valid = 1'b1;
        b1.tx_ready = 1'b1;
        @(posedge clk);
        for (int c = 1; c <= 13; c++) begin
            @(negedge clk);
            ph = (c - 1) % (N1 + 3 + G1);
            chk("g_tx_valid", 64'(b1.tx_valid), 64'(ph < N1 + 2));
            if (ph < N1 + 2) begin
                e1 = (ph == 0) ? 10'h200 : (ph == N1 + 1) ? 10'h100 : {2'b00, 8'hA5};
                chk("g_beat", 64'({b1.tx_frame_start, b1.tx_frame_end, b1.tx_data}), 64'(e1));
            end
            chk("g_done", 64'(b1.done), 64'(ph == N1 + 2));
            chk("g_busy", 64'(b1.busy), 64'(ph != N1 + 2 + G1));
            chk("g_in_ready", 64'(b1.in_ready), 64'(ph == N1 + 2 + G1));
        end
        b1.in_valid = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
